// File: rtl/cpu_defs.sv
// Shared CPU definitions for the front end.
//   - opcode_e      : RV32I major opcodes (inst[6:0])
//   - fetch_state_e : fetch FSM encoding (S_IDLE, S_MEM, S_JALR)
//   - immB / immJ   : sign-extended branch and jump immediates
package cpu_defs;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OPIMM  = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // looking up the icache at pc
        S_MEM  = 2'd1,  // miss outstanding, waiting for _mem_done
        S_JALR = 2'd2   // JALR emitted, waiting for the ROB to supply the target
    } fetch_state_e;

    // B-type: imm[12|10:5] in inst[31:25], imm[4:1|11] in inst[11:7]
    function automatic logic [31:0] immB(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    // J-type: imm[20|10:1|11|19:12] in inst[31:12]
    function automatic logic [31:0] immJ(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/inst_icache.sv
// Direct-mapped instruction cache, one 32-bit word per entry.
// Ports:
//   clk_in, rst_in : clock, async active-high reset (clears valid bits only)
//   rd_pc          : word address (pc[31:2]) for the combinational lookup
//   hit, rd_data   : lookup result
//   we, wr_pc, wr_data : synchronous fill of one entry
module inst_icache
    import cpu_defs::*;
#(
    parameter int IDX_W = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:2] rd_pc,
    output logic        hit,
    output logic [31:0] rd_data,
    input  logic        we,
    input  logic [31:2] wr_pc,
    input  logic [31:0] wr_data
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [31:0]        data_q [ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;

    assign rd_idx = rd_pc[IDX_W+1:2];
    assign rd_tag = rd_pc[31:IDX_W+2];
    assign wr_idx = wr_pc[IDX_W+1:2];
    assign wr_tag = wr_pc[31:IDX_W+2];

    assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_data = data_q[rd_idx];

    // Only the valid bits need a reset; tag/data are never read while invalid.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/inst_fetcher.sv
// Front-end fetch stage: holds the PC, looks up the icache, fetches misses
// from memory and pushes one instruction per cycle to the issue queue.
// Static prediction: JAL and branches taken, JALR stalls until the ROB
// resolves it, everything else falls through to pc+4.
// Ports:
//   clk_in, rst_in, rdy_in      : clock, async active-high reset, global enable
//   _clear, _clear_pc           : ROB flush and corrected PC (highest priority)
//   _need_inst                  : issue queue has space
//   _inst_out/_inst_addr_out/_jalr_rd/_inst_ready_out : pushed instruction, its PC, PC+4, push strobe
//   _jalr_done, _jalr_target    : ROB resolution of a stalled JALR
//   _mem_req/_mem_addr, _mem_data/_mem_done : memory fetch request and response
//
// Handshakes: _inst_ready_out is a one-cycle push, issued only while
// _need_inst is high in S_IDLE (a miss reserves its slot when requested).
// _mem_req is a level that stays high with a stable _mem_addr until the cycle
// _mem_done is sampled high (or _clear abandons it); _mem_done is a one-cycle
// strobe qualifying _mem_data and is ignored outside S_MEM.
module inst_fetcher
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ICACHE_IDX_W = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic [31:0] _clear_pc,
    input  logic        _need_inst,
    output logic [31:0] _inst_out,
    output logic        _inst_ready_out,
    output logic [31:0] _inst_addr_out,
    output logic [31:0] _jalr_rd,
    input  logic        _jalr_done,
    input  logic [31:0] _jalr_target,
    output logic        _mem_req,
    output logic [31:0] _mem_addr,
    input  logic [31:0] _mem_data,
    input  logic        _mem_done
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;

    logic        cache_hit;
    logic [31:0] cache_data;
    logic        cache_we;

    logic        emit;        // an instruction is pushed at this edge
    logic [31:0] emit_word;
    logic [31:0] pred_pc;     // predicted successor of emit_word
    logic        emit_jalr;
    logic        mem_req_d;
    logic [31:0] mem_addr_d;

    inst_icache #(
        .IDX_W(ICACHE_IDX_W)
    ) u_icache (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .rd_pc   (pc_q[31:2]),
        .hit     (cache_hit),
        .rd_data (cache_data),
        .we      (cache_we && rdy_in),
        .wr_pc   (pc_q[31:2]),
        .wr_data (_mem_data)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
        end else if (rdy_in) begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // ---------------- output / datapath decision ----------------
    always_comb begin
        emit       = 1'b0;
        emit_word  = cache_data;
        cache_we   = 1'b0;
        mem_req_d  = _mem_req;
        mem_addr_d = _mem_addr;
        if (_clear) begin
            // Abandon any in-flight request; a coincident _mem_done is not cached.
            mem_req_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (_need_inst) begin
                        if (cache_hit) begin
                            emit = 1'b1;
                        end else begin
                            mem_req_d  = 1'b1;
                            mem_addr_d = pc_q;
                        end
                    end
                end
                S_MEM: begin
                    // Queue space was reserved at request time, so _need_inst is not rechecked.
                    if (_mem_done) begin
                        emit      = 1'b1;
                        emit_word = _mem_data;
                        cache_we  = 1'b1;
                        mem_req_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Static next-PC prediction for the word being emitted.
    always_comb begin
        pred_pc   = pc_q + 32'd4;
        emit_jalr = 1'b0;
        case (emit_word[6:0])
            OPC_JAL:    pred_pc = pc_q + immJ(emit_word);
            OPC_BRANCH: pred_pc = pc_q + immB(emit_word);
            OPC_JALR: begin
                pred_pc   = pc_q;
                emit_jalr = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (_clear) begin
            state_d = S_IDLE;
            pc_d    = _clear_pc;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (emit) begin
                        pc_d    = pred_pc;
                        state_d = emit_jalr ? S_JALR : S_IDLE;
                    end else if (_need_inst) begin
                        state_d = S_MEM;
                    end
                end
                S_MEM: begin
                    if (_mem_done) begin
                        pc_d    = pred_pc;
                        state_d = emit_jalr ? S_JALR : S_IDLE;
                    end
                end
                S_JALR: begin
                    if (_jalr_done) begin
                        pc_d    = _jalr_target;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            _inst_ready_out <= 1'b0;
            _inst_out       <= '0;
            _inst_addr_out  <= '0;
            _jalr_rd        <= '0;
            _mem_req        <= 1'b0;
            _mem_addr       <= '0;
        end else if (rdy_in) begin
            _inst_ready_out <= emit;
            _mem_req        <= mem_req_d;
            _mem_addr       <= mem_addr_d;
            if (emit) begin
                _inst_out      <= emit_word;
                _inst_addr_out <= pc_q;
                _jalr_rd       <= pc_q + 32'd4;
            end
        end
    end

endmodule
